// File: rtl/static_image_source.sv
// static_image_source
// Streams a static image out of a synchronous frame memory in raster order
// on a valid/ready pixel interface. Reads are prefetched into a 2-entry FIFO
// so that with ready held high one pixel leaves per cycle. Playback is either
// one-shot (start pulse) or continuous (restart at end of frame).
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   start             begin one frame (only honoured in IDLE)
//   continuous        restart after the current frame (sampled on last pixel)
//   mem_rd_en         frame-memory read strobe
//   mem_addr          read address, y*IMG_WIDTH+x
//   mem_rdata         read data, valid one cycle after mem_rd_en
//   valid/ready       pixel handshake, transfer on valid && ready
//   pixel             pixel data (FIFO head)
//   sof, eol          first pixel of frame / last pixel of row qualifiers
//   busy              high whenever not IDLE
//   frame_done        one-cycle pulse after the final pixel transfers
module static_image_source #(
  parameter int IMG_WIDTH   = 800,
  parameter int IMG_HEIGHT  = 600,
  parameter int ADDR_WIDTH  = 19,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   continuous,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [PIXEL_WIDTH-1:0] mem_rdata,
  output logic                   valid,
  input  logic                   ready,
  output logic [PIXEL_WIDTH-1:0] pixel,
  output logic                   sof,
  output logic                   eol,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [XW-1:0]         LAST_X    = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]         LAST_Y    = YW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  fetch_addr;
  logic                   rd_vld_p1;      // read issued last cycle; mem_rdata is valid now
  logic [PIXEL_WIDTH-1:0] fifo_mem [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             fifo_count;
  logic [XW-1:0]          out_x;
  logic [YW-1:0]          out_y;
  logic                   frame_done_r;

  logic       pop;
  logic       issue;
  logic       last_pixel;
  logic [2:0] credit;

  assign valid      = (fifo_count != 2'd0);
  assign pixel      = fifo_mem[rd_ptr];
  assign pop        = valid && ready;
  // Slots already claimed: buffered + in flight, less the one leaving now.
  assign credit     = 3'(fifo_count) + 3'(rd_vld_p1) - 3'(pop);
  assign issue      = (state == STREAM) && (credit < 3'd2);
  assign mem_rd_en  = issue;
  assign mem_addr   = fetch_addr;
  assign last_pixel = pop && (out_x == LAST_X) && (out_y == LAST_Y);
  assign sof        = valid && (out_x == '0) && (out_y == '0);
  assign eol        = valid && (out_x == LAST_X);
  assign busy       = (state != IDLE);
  assign frame_done = frame_done_r;

  // Control: FSM, fetch address, FIFO pointers and output raster counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      fetch_addr   <= '0;
      rd_vld_p1    <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_count   <= 2'd0;
      out_x        <= '0;
      out_y        <= '0;
      frame_done_r <= 1'b0;
    end else begin
      rd_vld_p1    <= issue;
      frame_done_r <= last_pixel && (state == DRAIN);
      wr_ptr       <= wr_ptr ^ rd_vld_p1;
      rd_ptr       <= rd_ptr ^ pop;
      fifo_count   <= fifo_count + 2'(rd_vld_p1) - 2'(pop);

      if (pop) begin
        if (out_x == LAST_X) begin
          out_x <= '0;
          out_y <= (out_y == LAST_Y) ? '0 : out_y + 1'b1;
        end else begin
          out_x <= out_x + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state      <= STREAM;
            fetch_addr <= '0;
          end
        end
        STREAM: begin
          if (issue) begin
            if (fetch_addr == LAST_ADDR) begin
              // Park the address at 0 so mem_addr never leaves the image.
              state      <= DRAIN;
              fetch_addr <= '0;
            end else begin
              fetch_addr <= fetch_addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (last_pixel) begin
            state      <= continuous ? STREAM : IDLE;
            fetch_addr <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data: read return captured into the FIFO one cycle after the strobe
  always_ff @(posedge clock) begin
    if (rd_vld_p1) fifo_mem[wr_ptr] <= mem_rdata;
  end

endmodule

// File: tb/tb_static_image_source.sv
module tb_static_image_source;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 4;
  localparam int PW = 8;
  localparam int N  = W * H;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          ready = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_rdata;
  logic          valid;
  logic [PW-1:0] pixel;
  logic          sof, eol, busy, frame_done;

  int tests_run = 0;
  int failed = 0;

  static_image_source #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(AW), .PIXEL_WIDTH(PW)) dut (
    .clock(clock), .reset(reset), .start(start), .continuous(continuous),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .valid(valid), .ready(ready), .pixel(pixel), .sof(sof), .eol(eol),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  // Frame memory: mem[n] = n + 16, one-cycle read latency
  always @(posedge clock) begin
    if (mem_rd_en) mem_rdata <= PW'(mem_addr) + 8'd16;
  end

  // Monitor logs (sampled on the falling edge)
  int xfer_pix[$];
  bit xfer_sof[$];
  bit xfer_eol[$];
  int xfer_cyc[$];
  int addr_log[$];
  int cyc = 0;
  int fd_count = 0;
  int fd_cyc = -1;
  int first_valid_cyc = -1;
  int start_cyc = -1;
  int stall_viol = 0;
  int stall_cycles = 0;
  int max_out = 0;
  int issued = 0;
  int xfers_n = 0;
  int addr_over = 0;

  initial begin : monitor
    bit prev_stall = 1'b0;
    bit prev_valid = 1'b0;
    logic [PW-1:0] prev_pix = '0;
    logic prev_sof = 1'b0;
    logic prev_eol = 1'b0;
    int outstanding;
    forever begin
      @(negedge clock);
      cyc++;
      if (frame_done) begin
        fd_count++;
        fd_cyc = cyc;
      end
      if (!reset) begin
        if (start && !busy) start_cyc = cyc;
        if (valid && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (prev_stall && (!valid || pixel !== prev_pix || sof !== prev_sof || eol !== prev_eol))
          stall_viol++;
        if (valid && !ready) stall_cycles++;
        outstanding = issued - xfers_n - int'(valid && ready) + int'(mem_rd_en);
        if (outstanding > max_out) max_out = outstanding;
        if (mem_rd_en) begin
          addr_log.push_back(int'(mem_addr));
          issued++;
          if (int'(mem_addr) > N - 1) addr_over++;
        end
        if (valid && ready) begin
          xfer_pix.push_back(int'(pixel));
          xfer_sof.push_back(sof);
          xfer_eol.push_back(eol);
          xfer_cyc.push_back(cyc);
          xfers_n++;
        end
        prev_stall = valid && !ready;
        prev_pix   = pixel;
        prev_sof   = sof;
        prev_eol   = eol;
      end else begin
        prev_stall = 1'b0;
      end
      prev_valid = valid;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_logs();
    xfer_pix.delete(); xfer_sof.delete(); xfer_eol.delete(); xfer_cyc.delete();
    addr_log.delete();
    fd_count = 0; fd_cyc = -1; first_valid_cyc = -1; start_cyc = -1;
    stall_viol = 0; stall_cycles = 0; max_out = 0; issued = 0; xfers_n = 0; addr_over = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget, output bit ok);
    int n = 0;
    while (fd_count < target && n < budget) begin
      step(1);
      n++;
    end
    ok = (fd_count >= target);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; continuous = 1'b0; ready = 1'b0;
    step(3);
    tests_run++; if (valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b want 0", valid); end
    tests_run++; if (mem_rd_en !== 1'b0) begin failed++; $display("FAIL reset_rd_en got %b want 0", mem_rd_en); end
    tests_run++; if (mem_addr !== '0) begin failed++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
    tests_run++; if (sof !== 1'b0) begin failed++; $display("FAIL reset_sof got %b want 0", sof); end
    tests_run++; if (eol !== 1'b0) begin failed++; $display("FAIL reset_eol got %b want 0", eol); end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (frame_done !== 1'b0) begin failed++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_basic();
    bit ok;
    clear_logs();
    ready = 1'b1;
    pulse_start();
    wait_fd(1, 100, ok);
    step(3);
    tests_run++; if (!ok) begin failed++; $display("FAIL basic_timeout frame_done count %0d want 1", fd_count); end
    tests_run++; if (xfer_pix.size() != N) begin failed++; $display("FAIL basic_count got %0d want %0d", xfer_pix.size(), N); end
    for (int i = 0; i < xfer_pix.size(); i++) begin
      tests_run++; if (xfer_pix[i] != 16 + i) begin failed++; $display("FAIL basic_pixel[%0d] got %0d want %0d", i, xfer_pix[i], 16 + i); end
      tests_run++; if (xfer_sof[i] !== (i == 0)) begin failed++; $display("FAIL basic_sof[%0d] got %b want %b", i, xfer_sof[i], (i == 0)); end
      tests_run++; if (xfer_eol[i] !== (i % W == W - 1)) begin failed++; $display("FAIL basic_eol[%0d] got %b want %b", i, xfer_eol[i], (i % W == W - 1)); end
      tests_run++; if (xfer_cyc[i] != xfer_cyc[0] + i) begin failed++; $display("FAIL basic_back_to_back[%0d] cycle %0d want %0d", i, xfer_cyc[i], xfer_cyc[0] + i); end
    end
    tests_run++; if (first_valid_cyc - start_cyc != 3) begin failed++; $display("FAIL basic_latency got %0d cycles want 3", first_valid_cyc - start_cyc); end
    tests_run++; if (fd_count != 1) begin failed++; $display("FAIL basic_fd_count got %0d want 1", fd_count); end
    if (xfer_cyc.size() == N) begin
      tests_run++; if (fd_cyc != xfer_cyc[N-1] + 1) begin failed++; $display("FAIL basic_fd_timing got cycle %0d want %0d", fd_cyc, xfer_cyc[N-1] + 1); end
    end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL basic_busy_end got %b want 0", busy); end
    tests_run++; if (addr_log.size() != N) begin failed++; $display("FAIL basic_addr_count got %0d want %0d", addr_log.size(), N); end
    for (int i = 0; i < addr_log.size(); i++) begin
      tests_run++; if (addr_log[i] != i) begin failed++; $display("FAIL basic_addr[%0d] got %0d want %0d", i, addr_log[i], i); end
    end
  endtask

  task automatic test_stall();
    int pat [6] = '{1, 0, 0, 1, 0, 1};
    int k = 0;
    clear_logs();
    start = 1'b1;
    ready = pat[0][0];
    step(1);
    start = 1'b0;
    while (fd_count < 1 && k < 300) begin
      k++;
      ready = pat[k % 6][0];
      step(1);
    end
    ready = 1'b1;
    step(3);
    tests_run++; if (fd_count != 1) begin failed++; $display("FAIL stall_fd_count got %0d want 1", fd_count); end
    tests_run++; if (xfer_pix.size() != N) begin failed++; $display("FAIL stall_count got %0d want %0d", xfer_pix.size(), N); end
    for (int i = 0; i < xfer_pix.size(); i++) begin
      tests_run++; if (xfer_pix[i] != 16 + i) begin failed++; $display("FAIL stall_pixel[%0d] got %0d want %0d", i, xfer_pix[i], 16 + i); end
    end
    tests_run++; if (stall_cycles == 0) begin failed++; $display("FAIL stall_seen got %0d stall cycles want >0", stall_cycles); end
    tests_run++; if (stall_viol != 0) begin failed++; $display("FAIL stall_stable got %0d violations want 0", stall_viol); end
    tests_run++; if (max_out > 2) begin failed++; $display("FAIL stall_outstanding got %0d want <=2", max_out); end
    tests_run++; if (addr_over != 0) begin failed++; $display("FAIL stall_addr_range got %0d out of range want 0", addr_over); end
    tests_run++; if (addr_log.size() != N) begin failed++; $display("FAIL stall_addr_count got %0d want %0d", addr_log.size(), N); end
    for (int i = 0; i < addr_log.size(); i++) begin
      tests_run++; if (addr_log[i] != i) begin failed++; $display("FAIL stall_addr[%0d] got %0d want %0d", i, addr_log[i], i); end
    end
  endtask

  task automatic test_continuous();
    bit ok;
    int n = 0;
    clear_logs();
    continuous = 1'b1;
    ready = 1'b1;
    pulse_start();
    while (xfer_pix.size() < N + 2 && n < 100) begin
      step(1);
      n++;
    end
    continuous = 1'b0;
    wait_fd(2, 100, ok);
    step(20);
    tests_run++; if (!ok) begin failed++; $display("FAIL cont_timeout frame_done count %0d want 2", fd_count); end
    tests_run++; if (fd_count != 2) begin failed++; $display("FAIL cont_fd_count got %0d want 2", fd_count); end
    tests_run++; if (xfer_pix.size() != 2 * N) begin failed++; $display("FAIL cont_count got %0d want %0d", xfer_pix.size(), 2 * N); end
    for (int i = 0; i < xfer_pix.size(); i++) begin
      tests_run++; if (xfer_pix[i] != 16 + (i % N)) begin failed++; $display("FAIL cont_pixel[%0d] got %0d want %0d", i, xfer_pix[i], 16 + (i % N)); end
      tests_run++; if (xfer_sof[i] !== (i % N == 0)) begin failed++; $display("FAIL cont_sof[%0d] got %b want %b", i, xfer_sof[i], (i % N == 0)); end
    end
    if (xfer_cyc.size() > N) begin
      tests_run++; if (xfer_cyc[N] - xfer_cyc[N-1] > 3) begin failed++; $display("FAIL cont_gap got %0d cycles between frames want <=3", xfer_cyc[N] - xfer_cyc[N-1]); end
    end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL cont_busy_end got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    clear_logs();
    ready = 1'b1;
    pulse_start();
    while (xfer_pix.size() < 5 && n < 50) begin
      step(1);
      n++;
    end
    reset = 1'b1;
    step(1);
    tests_run++; if (valid !== 1'b0) begin failed++; $display("FAIL midrst_valid got %b want 0", valid); end
    tests_run++; if (mem_rd_en !== 1'b0) begin failed++; $display("FAIL midrst_rd_en got %b want 0", mem_rd_en); end
    tests_run++; if (mem_addr !== '0) begin failed++; $display("FAIL midrst_addr got %0d want 0", mem_addr); end
    tests_run++; if (sof !== 1'b0 || eol !== 1'b0) begin failed++; $display("FAIL midrst_sof_eol got %b%b want 00", sof, eol); end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL midrst_busy got %b want 0", busy); end
    tests_run++; if (frame_done !== 1'b0) begin failed++; $display("FAIL midrst_frame_done got %b want 0", frame_done); end
    reset = 1'b0;
    step(10);
    tests_run++; if (fd_count != 0) begin failed++; $display("FAIL midrst_no_fd got %0d pulses want 0", fd_count); end
    tests_run++; if (xfer_pix.size() != 5) begin failed++; $display("FAIL midrst_xfers got %0d want 5", xfer_pix.size()); end
    clear_logs();
    pulse_start();
    wait_fd(1, 100, ok);
    step(3);
    tests_run++; if (xfer_pix.size() != N) begin failed++; $display("FAIL midrst_replay_count got %0d want %0d", xfer_pix.size(), N); end
    if (xfer_pix.size() > 0) begin
      tests_run++; if (xfer_pix[0] != 16) begin failed++; $display("FAIL midrst_replay_first got %0d want 16", xfer_pix[0]); end
      tests_run++; if (xfer_sof[0] !== 1'b1) begin failed++; $display("FAIL midrst_replay_sof got %b want 1", xfer_sof[0]); end
    end
  endtask

  task automatic test_start_busy();
    bit ok;
    int n = 0;
    clear_logs();
    ready = 1'b1;
    pulse_start();
    step(2);
    tests_run++; if (busy !== 1'b1) begin failed++; $display("FAIL busy_stream got %b want 1", busy); end
    pulse_start();
    while (xfer_pix.size() < 10 && n < 50) begin
      step(1);
      n++;
    end
    tests_run++; if (busy !== 1'b1) begin failed++; $display("FAIL busy_drain got %b want 1", busy); end
    pulse_start();
    wait_fd(1, 100, ok);
    step(10);
    tests_run++; if (xfer_pix.size() != N) begin failed++; $display("FAIL busy_start_count got %0d want %0d", xfer_pix.size(), N); end
    tests_run++; if (fd_count != 1) begin failed++; $display("FAIL busy_start_fd got %0d want 1", fd_count); end
    tests_run++; if (addr_log.size() != N) begin failed++; $display("FAIL busy_start_reads got %0d want %0d", addr_log.size(), N); end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL busy_start_end got %b want 0", busy); end
  endtask

  task automatic test_start_reset();
    clear_logs();
    start = 1'b1;
    reset = 1'b1;
    step(1);
    start = 1'b0;
    reset = 1'b0;
    step(5);
    tests_run++; if (addr_log.size() != 0) begin failed++; $display("FAIL start_reset_reads got %0d want 0", addr_log.size()); end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL start_reset_busy got %b want 0", busy); end
    tests_run++; if (valid !== 1'b0) begin failed++; $display("FAIL start_reset_valid got %b want 0", valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_continuous();
    test_reset_mid();
    test_start_busy();
    test_start_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, tests run %0d", tests_run);
    $fatal(1);
  end

endmodule

// File: doc/static_image_source.md
Name: static_image_source

Overview:
Pixel-stream producer that reads a stored static image from a synchronous frame memory and emits it in raster order on a valid/ready pixel interface. It drives the upstream end of the blanking/framing stage: it presents pixel+valid, and the consumer controls flow with ready. It supports one-shot or continuous frame playback, and marks start-of-frame and end-of-line.

Parameters:
IMG_WIDTH, 800, active pixels per row
IMG_HEIGHT, 600, active rows per frame
ADDR_WIDTH, 19, frame-memory address width; must satisfy 2^ADDR_WIDTH >= IMG_WIDTH*IMG_HEIGHT
PIXEL_WIDTH, 8, pixel width in bits

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin one frame; sampled only in IDLE
continuous  in  1  1 = restart automatically after each frame; sampled at end of frame
mem_rd_en  out  1  frame-memory read strobe
mem_addr  out  ADDR_WIDTH  read address, linear raster index y*IMG_WIDTH+x
mem_rdata  in  PIXEL_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
valid  out  1  pixel is valid
ready  in  1  consumer accepts pixel this cycle
pixel  out  PIXEL_WIDTH  pixel data
sof  out  1  qualifies the current pixel as the first pixel of the frame (x=0, y=0)
eol  out  1  qualifies the current pixel as the last pixel of its row (x=IMG_WIDTH-1)
busy  out  1  high in any state except IDLE
frame_done  out  1  1-cycle pulse after the last pixel of a frame transfers

Behaviour:
- Reset: state=IDLE; valid=0, mem_rd_en=0, mem_addr=0, sof=0, eol=0, busy=0, frame_done=0; the FIFO is emptied, the fetch and output counters are cleared, and any in-flight read is discarded. Reset mid-frame aborts the frame and does not pulse frame_done.
- Transfer: a transfer occurs when valid && ready. While valid && !ready, pixel, sof and eol hold stable. Once valid is asserted, it never drops without a transfer.
- Buffering: a 2-entry FIFO holds read data. Credit = fifo_count + inflight - pop. A read issues only when credit < 2 and fetch_addr <= IMG_WIDTH*IMG_HEIGHT-1. mem_rdata is written into the FIFO on the cycle after mem_rd_en. valid = FIFO not empty; pixel = FIFO head.
- Throughput: with ready held high, one pixel transfers per cycle after the first.
- Latency: valid first rises on the 2nd clock edge after the edge that samples start.
- States:
  - IDLE: no reads are issued. start=1 moves to STREAM with fetch_addr=0. start=0 stays in IDLE.
  - STREAM: reads are issued per the credit rule, and fetch_addr increments on each issue. When the last address is issued, the state moves to DRAIN.
  - DRAIN: no reads are issued. When the final pixel transfers (out_x=IMG_WIDTH-1, out_y=IMG_HEIGHT-1), frame_done pulses on the next cycle. If continuous=1 at that transfer, the state goes to STREAM with fetch_addr=0; otherwise it goes to IDLE.
- Output counters: out_x and out_y advance on each transfer. out_x wraps to 0 at IMG_WIDTH-1, and out_y increments on that wrap. Both wrap to 0 after the final pixel.
  - sof = valid && out_x==0 && out_y==0.
  - eol = valid && out_x==IMG_WIDTH-1.
- Boundary conditions:
  - start while busy is ignored.
  - start and reset in the same cycle: reset wins.
  - A continuous change mid-frame takes effect only at end of frame.
  - Continuous mode with ready high: the gap between the last pixel of frame N and the first pixel of frame N+1 is at most 2 cycles, and no pixel is dropped or duplicated.
  - mem_addr never exceeds IMG_WIDTH*IMG_HEIGHT-1.
  - The FIFO never overflows: inflight + fifo_count <= 2 always.

Test Plan:
- Run with IMG_WIDTH=4, IMG_HEIGHT=3, mem[n]=n+16, ready=1, pulse start once -> 12 transfers, pixel=16..27 in order, on consecutive cycles. sof on pixel 16 only; eol on 19, 23 and 27. frame_done pulses once, one cycle after 27. Return to IDLE with busy=0.
- Same setup with a ready pattern of 1,0,0,1,0,1 repeating -> pixel/sof/eol stable during every stall, all 12 values delivered exactly once in order. mem_addr covers 0..11 once each. Never more than 2 reads are outstanding or buffered.
- continuous=1, ready=1, start once -> frame 2 begins within 2 cycles of frame 1 ending and again starts with pixel 16 plus sof. Drop continuous during frame 2 -> exactly 2 frames, then IDLE.
- Reset asserted after the 5th transfer -> all outputs are at reset values the next cycle. No frame_done pulse. A later start replays from pixel 16 with sof.
- A start pulse while in STREAM or DRAIN -> ignored: exactly 12 transfers and one frame_done.
- start then reset in the same cycle -> remains in IDLE, no mem_rd_en.
